// File: rtl/audio_mix_pkg.sv
// Shared types, constants and elaboration helpers for the audio mixer and its
// per-side 1-bit DACs.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLAMP = 2'd2
    } mix_state_t;

    localparam int DAC_SIGMA_DELTA = 0;
    localparam int DAC_LEAKY_INT   = 1;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Offset-binary zero: MSB set, everything below clear.
    function automatic logic [31:0] midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/audio_mix_dac_if.sv
// Sample-source side of the mixer: per-channel PCM/gain/pan inputs, strobes,
// and the mixed PCM, status flags and DAC bitstreams coming back.
interface audio_mix_dac_if #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 16
);
    logic                         cen_sample;
    logic [CHANNELS*SAMPLE_W-1:0] ch_data;
    logic [CHANNELS*3-1:0]        ch_shift;
    logic [CHANNELS*2-1:0]        ch_pan;
    logic                         clip_clr;

    logic [SAMPLE_W-1:0]          sample_l;
    logic [SAMPLE_W-1:0]          sample_r;
    logic                         sample_valid;
    logic                         busy;
    logic                         overrun;
    logic                         clip_l;
    logic                         clip_r;
    logic                         aud_l;
    logic                         aud_r;

    modport master (
        output cen_sample, ch_data, ch_shift, ch_pan, clip_clr,
        input  sample_l, sample_r, sample_valid, busy, overrun,
               clip_l, clip_r, aud_l, aud_r
    );

    modport slave (
        input  cen_sample, ch_data, ch_shift, ch_pan, clip_clr,
        output sample_l, sample_r, sample_valid, busy, overrun,
               clip_l, clip_r, aud_l, aud_r
    );
endinterface

// File: rtl/sigma_delta_dac.sv
// One-side 1-bit DAC: first-order error-feedback sigma-delta, or the legacy
// leaky-integrator comparator, chosen at elaboration time.
module sigma_delta_dac
    import audio_mix_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int DAC_MODE   = DAC_SIGMA_DELTA,
    parameter int LEAK_SHIFT = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                aud
);

    if (DAC_MODE == DAC_SIGMA_DELTA) begin : g_error_feedback
        logic [SAMPLE_W:0] sd;

        // NOTE: state registers use <= so every flop samples pre-edge values,
        // independent of statement order or of other always_ff blocks.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sd <= '0;
            end else begin
                sd <= {1'b0, sd[SAMPLE_W-1:0]} + {1'b0, sample};
            end
        end

        // The carry out of the phase accumulator is the bitstream.
        assign aud = sd[SAMPLE_W];
    end else begin : g_leaky_integrator
        localparam int INT_W = 2 * SAMPLE_W;
        localparam logic [INT_W-1:0] STEP = {{(INT_W-1){1'b0}}, 1'b1} << (INT_W - LEAK_SHIFT);

        logic [INT_W-1:0] v;
        logic             below;
        logic             bit_q;

        assign below = v[INT_W-1 -: SAMPLE_W] < sample;

        // Comparator decision is registered so the pin idles low in reset.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                v     <= '0;
                bit_q <= 1'b0;
            end else begin
                v     <= v - (v >> LEAK_SHIFT) + (below ? STEP : '0);
                bit_q <= below;
            end
        end

        assign aud = bit_q;
    end

endmodule

// File: rtl/audio_mix_dac.sv
// Multi-channel serial mixer: snapshots all channels on cen_sample, applies
// shift-gain and pan one channel per clock, saturates, and feeds two 1-bit DACs.
module audio_mix_dac
    import audio_mix_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int SAMPLE_W   = 16,
    parameter int DAC_MODE   = DAC_SIGMA_DELTA,
    parameter int LEAK_SHIFT = 7
) (
    input  logic           clk,
    input  logic           reset_n,
    audio_mix_dac_if.slave bus
);

    localparam int IDX_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
    localparam int ACC_W = SAMPLE_W + 7 + clog2(CHANNELS);
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(CHANNELS - 1);
    localparam logic [SAMPLE_W-1:0]     MIDSCALE  = SAMPLE_W'(midscale(SAMPLE_W));
    localparam logic signed [ACC_W-1:0] POS_LIMIT = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_LIMIT = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    mix_state_t state;
    logic [IDX_W-1:0] idx;

    logic signed [SAMPLE_W-1:0] snap_data  [CHANNELS];
    logic        [2:0]          snap_shift [CHANNELS];
    logic        [1:0]          snap_pan   [CHANNELS];

    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] term;
    logic        [1:0]       term_pan;
    logic        [SAMPLE_W:0] sat_l;
    logic        [SAMPLE_W:0] sat_r;

    logic [SAMPLE_W-1:0] sample_l_q;
    logic [SAMPLE_W-1:0] sample_r_q;
    logic                sample_valid_q;
    logic                overrun_q;
    logic                clip_l_q;
    logic                clip_r_q;
    logic                accept;

    // Returns {clip, offset-binary sample}.
    function automatic logic [SAMPLE_W:0] saturate(input logic signed [ACC_W-1:0] acc);
        if (acc > POS_LIMIT) begin
            return {1'b1, {SAMPLE_W{1'b1}}};
        end else if (acc < NEG_LIMIT) begin
            return {1'b1, {SAMPLE_W{1'b0}}};
        end else begin
            return {1'b0, ~acc[SAMPLE_W-1], acc[SAMPLE_W-2:0]};
        end
    endfunction

    assign accept = (state == IDLE) && bus.cen_sample;

    // NOTE: the snapshot bank is always written before it is read, so it
    // carries no reset; only control state and visible outputs are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < CHANNELS; i++) begin
                snap_data[i]  <= bus.ch_data[i*SAMPLE_W +: SAMPLE_W];
                snap_shift[i] <= bus.ch_shift[i*3 +: 3];
                snap_pan[i]   <= bus.ch_pan[i*2 +: 2];
            end
        end
    end

    // NOTE: every always_comb output gets a value on every path, so no
    // latches are inferred.
    always_comb begin
        term     = {{(ACC_W-SAMPLE_W){snap_data[idx][SAMPLE_W-1]}}, snap_data[idx]} <<< snap_shift[idx];
        term_pan = snap_pan[idx];
        sat_l    = saturate(acc_l);
        sat_r    = saturate(acc_r);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            acc_l          <= '0;
            acc_r          <= '0;
            sample_l_q     <= MIDSCALE;
            sample_r_q     <= MIDSCALE;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            clip_l_q       <= 1'b0;
            clip_r_q       <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            overrun_q      <= bus.cen_sample && (state != IDLE);
            clip_l_q       <= clip_l_q && !bus.clip_clr;
            clip_r_q       <= clip_r_q && !bus.clip_clr;

            case (state)
                IDLE: begin
                    if (bus.cen_sample) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (term_pan[0]) acc_l <= acc_l + term;
                    if (term_pan[1]) acc_r <= acc_r + term;
                    if (idx == LAST_IDX) begin
                        state <= CLAMP;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                CLAMP: begin
                    sample_l_q     <= sat_l[SAMPLE_W-1:0];
                    sample_r_q     <= sat_r[SAMPLE_W-1:0];
                    sample_valid_q <= 1'b1;
                    // Placed after the clear above so a same-cycle clip wins.
                    if (sat_l[SAMPLE_W]) clip_l_q <= 1'b1;
                    if (sat_r[SAMPLE_W]) clip_r_q <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample_l     = sample_l_q;
    assign bus.sample_r     = sample_r_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.busy         = (state != IDLE);
    assign bus.overrun      = overrun_q;
    assign bus.clip_l       = clip_l_q;
    assign bus.clip_r       = clip_r_q;

    sigma_delta_dac #(
        .SAMPLE_W   (SAMPLE_W),
        .DAC_MODE   (DAC_MODE),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_dac_l (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (sample_l_q),
        .aud     (bus.aud_l)
    );

    sigma_delta_dac #(
        .SAMPLE_W   (SAMPLE_W),
        .DAC_MODE   (DAC_MODE),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_dac_r (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (sample_r_q),
        .aud     (bus.aud_r)
    );

endmodule

// File: tb/tb_audio_mix_dac.sv
`timescale 1ns/1ps
// Bench for audio_mix_dac: an arithmetic sample-level model compared every cycle
// against both DAC variants, plus directed literal expectations.
module tb_audio_mix_dac;

    localparam int CH = 4;
    localparam int SW = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    audio_mix_dac_if #(.CHANNELS(CH), .SAMPLE_W(SW)) bus0 ();
    audio_mix_dac_if #(.CHANNELS(CH), .SAMPLE_W(SW)) bus1 ();

    assign bus1.cen_sample = bus0.cen_sample;
    assign bus1.ch_data    = bus0.ch_data;
    assign bus1.ch_shift   = bus0.ch_shift;
    assign bus1.ch_pan     = bus0.ch_pan;
    assign bus1.clip_clr   = bus0.clip_clr;

    audio_mix_dac #(.CHANNELS(CH), .SAMPLE_W(SW), .DAC_MODE(0), .LEAK_SHIFT(7)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    audio_mix_dac #(.CHANNELS(CH), .SAMPLE_W(SW), .DAC_MODE(1), .LEAK_SHIFT(7)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model: sums signed values arithmetically ----------------
    int m_rem     = 0;
    int m_l       = 32768;
    int m_r       = 32768;
    int p_l       = 0;
    int p_r       = 0;
    bit p_cl      = 1'b0;
    bit p_cr      = 1'b0;
    bit m_valid   = 1'b0;
    bit m_overrun = 1'b0;
    bit m_clip_l  = 1'b0;
    bit m_clip_r  = 1'b0;
    int m_sd_l    = 0;
    int m_sd_r    = 0;

    function automatic void mix(input int side, output int res, output bit clip);
        longint sum;
        sum = 0;
        for (int i = 0; i < CH; i++) begin
            if (bus0.ch_pan[i*2 + side])
                sum += longint'($signed(bus0.ch_data[i*SW +: SW])) * (longint'(1) << bus0.ch_shift[i*3 +: 3]);
        end
        clip = 1'b0;
        if (sum > 32767) begin
            res = 65535; clip = 1'b1;
        end else if (sum < -32768) begin
            res = 0; clip = 1'b1;
        end else begin
            res = int'(sum) + 32768;
        end
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_rem = 0; m_l = 32768; m_r = 32768; m_valid = 1'b0; m_overrun = 1'b0;
            m_clip_l = 1'b0; m_clip_r = 1'b0; m_sd_l = 0; m_sd_r = 0;
        end else begin
            m_sd_l    = (m_sd_l % 65536) + m_l;
            m_sd_r    = (m_sd_r % 65536) + m_r;
            m_valid   = 1'b0;
            m_overrun = 1'b0;
            m_clip_l  = m_clip_l && !bus0.clip_clr;
            m_clip_r  = m_clip_r && !bus0.clip_clr;
            if (m_rem > 0) begin
                m_overrun = bus0.cen_sample;
                m_rem--;
                if (m_rem == 0) begin
                    m_l = p_l; m_r = p_r; m_valid = 1'b1;
                    if (p_cl) m_clip_l = 1'b1;
                    if (p_cr) m_clip_r = 1'b1;
                end
            end else if (bus0.cen_sample) begin
                mix(0, p_l, p_cl);
                mix(1, p_r, p_cr);
                m_rem = CH + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_sample_l",  bus0.sample_l,     m_l);
            check("cyc_sample_r",  bus0.sample_r,     m_r);
            check("cyc_valid",     bus0.sample_valid, m_valid);
            check("cyc_busy",      bus0.busy,         m_rem > 0);
            check("cyc_overrun",   bus0.overrun,      m_overrun);
            check("cyc_clip_l",    bus0.clip_l,       m_clip_l);
            check("cyc_clip_r",    bus0.clip_r,       m_clip_r);
            check("cyc_aud_l",     bus0.aud_l,        m_sd_l / 65536);
            check("cyc_aud_r",     bus0.aud_r,        m_sd_r / 65536);
            check("cyc_m1_sample_l", bus1.sample_l,   m_l);
            check("cyc_m1_sample_r", bus1.sample_r,   m_r);
            check("cyc_m1_valid",  bus1.sample_valid, m_valid);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mute_all();
        bus0.ch_data  = {CH{16'h5A5A}};
        bus0.ch_shift = {CH{3'd7}};
        bus0.ch_pan   = '0;
    endtask

    task automatic set_ch(input int i, input logic [15:0] d, input logic [2:0] s, input logic [1:0] p);
        bus0.ch_data[i*SW +: SW] = d;
        bus0.ch_shift[i*3 +: 3]  = s;
        bus0.ch_pan[i*2 +: 2]    = p;
    endtask

    task automatic strobe(output int t);
        bus0.cen_sample = 1'b1;
        t = cyc;
        tick();
        bus0.cen_sample = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus0.sample_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Run one sweep and compare the result against literal expectations.
    task automatic sweep(input string name, input logic [15:0] exp_l, input logic [15:0] exp_r);
        int t;
        int at;
        strobe(t);
        wait_valid(20, at);
        check({name, "_latency"}, at - t, CH + 2);
        check({name, "_l"}, bus0.sample_l, exp_l);
        check({name, "_r"}, bus0.sample_r, exp_r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n_valid;
        logic [15:0] last_l;
        int cnt0_l, cnt0_r, cnt1_l, cnt1_r;

        bus0.cen_sample = 1'b0;
        bus0.clip_clr   = 1'b0;
        mute_all();
        reset_n = 1'b0;
        tick();
        cmp_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_sample_l", bus0.sample_l, 16'h8000);
        check("rst_sample_r", bus0.sample_r, 16'h8000);
        check("rst_busy",     bus0.busy, 1'b0);
        check("rst_flags",    {bus0.sample_valid, bus0.overrun, bus0.clip_l, bus0.clip_r}, 4'b0);
        check("rst_aud0",     {bus0.aud_l, bus0.aud_r}, 2'b00);
        check("rst_aud1",     {bus1.aud_l, bus1.aud_r}, 2'b00);
        tick();
        reset_n = 1'b1;
        tick();

        // Single channel, other channels carry large muted values.
        mute_all();
        set_ch(0, 16'h1000, 3'd0, 2'b11);
        sweep("single", 16'h9000, 16'h9000);
        check("single_noclip", {bus0.clip_l, bus0.clip_r}, 2'b00);
        tick();

        // Positive and negative saturation on the left only.
        mute_all();
        set_ch(0, 16'h7000, 3'd0, 2'b01);
        set_ch(1, 16'h7000, 3'd0, 2'b01);
        sweep("sat_pos", 16'hFFFF, 16'h8000);
        check("sat_pos_clip", {bus0.clip_l, bus0.clip_r}, 2'b10);
        tick();
        set_ch(0, 16'h8000, 3'd0, 2'b01);
        set_ch(1, 16'h8000, 3'd0, 2'b01);
        sweep("sat_neg", 16'h0000, 16'h8000);
        tick();
        bus0.clip_clr = 1'b1;
        tick();
        bus0.clip_clr = 1'b0;
        @(negedge clk);
        check("clip_cleared", bus0.clip_l, 1'b0);
        tick();

        // Clear held through a clipping sweep: set wins, then clear takes over.
        bus0.clip_clr = 1'b1;
        sweep("set_wins", 16'h0000, 16'h8000);
        check("set_wins_clip", bus0.clip_l, 1'b1);
        tick();
        @(negedge clk);
        check("clr_after_set", bus0.clip_l, 1'b0);
        bus0.clip_clr = 1'b0;
        tick();

        // Gain and pan split.
        mute_all();
        set_ch(0, 16'h0400, 3'd3, 2'b01);
        set_ch(1, 16'hE000, 3'd0, 2'b10);
        sweep("gain_pan", 16'hA000, 16'h6000);
        tick();

        // Exact full-scale boundaries, no clip.
        mute_all();
        set_ch(0, 16'h7FFF, 3'd0, 2'b01);
        set_ch(1, 16'h8000, 3'd0, 2'b10);
        sweep("edge", 16'hFFFF, 16'h0000);
        check("edge_noclip", {bus0.clip_l, bus0.clip_r}, 2'b00);
        tick();

        // One LSB past full scale.
        set_ch(1, 16'h0001, 3'd0, 2'b01);
        sweep("over1", 16'hFFFF, 16'h8000);
        check("over1_clip", {bus0.clip_l, bus0.clip_r}, 2'b10);
        tick();

        // Cancelling terms across gains and pans.
        mute_all();
        set_ch(0, 16'h0100, 3'd4, 2'b11);
        set_ch(1, 16'hFF00, 3'd4, 2'b01);
        set_ch(2, 16'h0010, 3'd7, 2'b10);
        set_ch(3, 16'hFFFF, 3'd0, 2'b11);
        sweep("mixed", 16'h7FFF, 16'h97FF);
        tick();

        // Worst-case magnitude: all channels at -full-scale, maximum gain.
        for (int i = 0; i < CH; i++) set_ch(i, 16'h8000, 3'd7, 2'b11);
        sweep("max_gain", 16'h0000, 16'h0000);
        check("max_gain_clip", {bus0.clip_l, bus0.clip_r}, 2'b11);
        tick();

        // Overrun: second strobe two cycles later is dropped.
        mute_all();
        set_ch(0, 16'h1234, 3'd0, 2'b11);
        bus0.cen_sample = 1'b1;
        t = cyc;
        tick();
        bus0.cen_sample = 1'b0;
        tick();
        set_ch(0, 16'h0001, 3'd0, 2'b11);
        bus0.cen_sample = 1'b1;
        tick();
        bus0.cen_sample = 1'b0;
        @(negedge clk);
        check("overrun_pulse", bus0.overrun, 1'b1);
        n_valid = 0;
        last_l  = 16'h0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus0.sample_valid) begin
                n_valid++;
                last_l = bus0.sample_l;
            end
        end
        check("overrun_one_valid", n_valid, 1);
        check("overrun_first_kept", last_l, 16'h9234);
        tick();

        // Reset in the middle of a sweep.
        mute_all();
        set_ch(0, 16'h1000, 3'd0, 2'b11);
        strobe(t);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_sample_l", bus0.sample_l, 16'h8000);
        check("abort_sample_r", bus0.sample_r, 16'h8000);
        check("abort_busy",     bus0.busy, 1'b0);
        check("abort_clips",    {bus0.clip_l, bus0.clip_r}, 2'b00);
        check("abort_aud",      {bus0.aud_l, bus1.aud_l}, 2'b00);
        n_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus0.sample_valid) n_valid++;
        end
        check("abort_no_valid", n_valid, 0);
        tick();

        // DAC density with sample_l = 0xC000, sample_r = midscale.
        mute_all();
        set_ch(0, 16'h4000, 3'd0, 2'b01);
        sweep("dac_setup", 16'hC000, 16'h8000);
        repeat (4096) tick();
        cnt0_l = 0; cnt0_r = 0; cnt1_l = 0; cnt1_r = 0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            cnt0_l += int'(bus0.aud_l);
            cnt0_r += int'(bus0.aud_r);
            cnt1_l += int'(bus1.aud_l);
            cnt1_r += int'(bus1.aud_r);
        end
        check("dac0_density_l", cnt0_l, 49152);
        check("dac0_density_r", cnt0_r, 32768);
        check("dac1_density_l_in_range", (cnt1_l >= 48169) && (cnt1_l <= 50135), 1'b1);
        check("dac1_density_r_in_range", (cnt1_r >= 32113) && (cnt1_r <= 33423), 1'b1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_mix_dac.md
# audio_mix_dac

Parametrised multi-channel audio mixer with 1-bit stereo DAC output, sitting between the sound sources (OPL2, Tandy PSG, PC speaker, future cards) and the AUD_L/AUD_R board pins. On each sample strobe it snapshots CHANNELS signed inputs, applies per-channel shift-gain and L/R pan, and sums them serially. It then saturates each side to SAMPLE_W bits and drives a per-side sigma-delta modulator running every clock. Successor to the fixed three-source mixer: generalised channel count and width, stereo pan, clip reporting, and selectable modulator type.

## Interface
- CHANNELS, 4: number of input channels, 1..16
- SAMPLE_W, 16: input and output PCM width
- DAC_MODE, 0: 0 = first-order error-feedback sigma-delta; 1 = leaky-integrator comparator (legacy behaviour)
- LEAK_SHIFT, 7: integrator leak shift, DAC_MODE=1 only
- clk  in  1  mixer/DAC clock (clk_vga domain, 28.636 MHz)
- reset_n  in  1  synchronous, active-low reset
- cen_sample  in  1  one-cycle sample strobe, starts a mix sweep
- ch_data  in  CHANNELS*SAMPLE_W  packed signed samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
- ch_shift  in  CHANNELS*3  per-channel left-shift gain 0..7
- ch_pan  in  CHANNELS*2  bit0 = route to left, bit1 = route to right; 00 = mute
- clip_clr  in  1  clears sticky clip flags
- sample_l, sample_r  out  SAMPLE_W  saturated mix, offset-binary (midscale = 1 followed by zeros)
- sample_valid  out  1  one-cycle pulse when sample_l/r update
- busy  out  1  sweep in progress
- overrun  out  1  one-cycle pulse, cen_sample rejected
- clip_l, clip_r  out  1  sticky saturation flags
- aud_l, aud_r  out  1  modulator bitstreams

## Operation
- States: IDLE, ACCUM, CLAMP. IDLE + cen_sample: snapshot ch_data/ch_shift/ch_pan into registers, clear both accumulators, idx=0, go to ACCUM.
- ACCUM: one channel per cycle; term = sign-extend(ch_data[idx]) <<< ch_shift[idx], added to acc_l if pan bit0 set and to acc_r if pan bit1 set. After idx=CHANNELS-1, go to CLAMP.
- Accumulator width ACC_W = SAMPLE_W + 7 + clog2(CHANNELS); no internal overflow is possible.
- CLAMP: per side, if acc > 2^(SAMPLE_W-1)-1, result = all ones, set clip; if acc < -2^(SAMPLE_W-1), result = all zeros, set clip; else result = acc[SAMPLE_W-1:0] with MSB inverted. Register to sample_l/r, pulse sample_valid, return to IDLE.
- cen_sample while busy: ignored, overrun pulses, the sweep in progress is unaffected.
- clip_clr and a same-cycle clip event: set wins.
- DAC_MODE=0: per side, INT_W = SAMPLE_W+1; every clk, sd <= {1'b0, sd[SAMPLE_W-1:0]} + sample; aud = sd[SAMPLE_W]. Density of aud equals sample / 2^SAMPLE_W.
- DAC_MODE=1: INT_W = 2*SAMPLE_W; bit = (v[INT_W-1 -: SAMPLE_W] < sample); v <= v - (v >> LEAK_SHIFT) + (bit << (INT_W-LEAK_SHIFT)); aud = bit.
- The modulator always runs on the currently registered sample_l/r.

## Timing
- cen_sample high in cycle t: busy is high in cycles t+1 .. t+CHANNELS+1. sample_valid and new sample_l/r appear in cycle t+CHANNELS+2, and busy is low in that cycle.
- Earliest accepted next strobe: cycle t+CHANNELS+2. The strobe period must be at least CHANNELS+2 cycles.
- The modulator sees a new sample one cycle after sample_valid.
- Reset values: sample_l/r = midscale (16'h8000 at default width); sample_valid, busy, overrun, clip_l, clip_r, aud_l, aud_r = 0; all accumulators and integrators = 0; state = IDLE.
- reset_n low mid-sweep aborts the sweep. All reset values hold in the cycle after the sampling edge, and no sample_valid is emitted.

## Structure
- Package audio_mix_pkg: state enum (IDLE/ACCUM/CLAMP), clog2 function, DAC_MODE constants, midscale constant function.
- Sub-module sigma_delta_dac (parameters SAMPLE_W, DAC_MODE, LEAK_SHIFT; ports clk, reset_n, sample, aud), instantiated once per side.
- The top level holds the snapshot bank, sweep FSM, accumulators and clamp.

## Test plan
- Reset: hold reset_n low 3 cycles -> sample_l = sample_r = 16'h8000, all flags/aud = 0, busy = 0.
- Single channel: ch0 = 16'h1000, shift 0, pan 11, others muted, strobe at t -> sample_l = sample_r = 16'h9000, sample_valid at t+6 (CHANNELS=4), no clip.
- Saturation and pan: ch0 = ch1 = 16'h7000, pan 01 -> sample_l = 16'hFFFF, clip_l = 1, clip_r = 0, sample_r = 16'h8000. Then ch0 = ch1 = 16'h8000 -> sample_l = 16'h0000. clip_clr -> clip_l = 0.
- Gain/pan split: ch0 = 16'h0400 shift 3 pan 01, ch1 = 16'hE000 pan 10 -> sample_l = 16'hA000, sample_r = 16'h6000.
- DAC density, mode 0: sample_l = 16'hC000 held, count aud_l over 65536 cycles -> exactly 49152 ones. Mode 1 -> 49152 ±2% after 4096 settling cycles.
- Overrun/reset: strobe at t and t+2 -> overrun pulse at t+3, one sample_valid only, result matches the t snapshot. reset_n low at t+3 -> no sample_valid, outputs at reset values.
